// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB444 capture stage driving the frame BRAM write port
// Frame-synchronised: skips settling frames, then writes whole frames pixel by pixel.
module ov7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              line_err
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

  typedef enum logic [1:0] {ST_WAIT_VS_HI, ST_WAIT_VS_LO, ST_SKIP, ST_ACTIVE} state_e;

  state_e              state_q, state_d;
  logic                vsync_q, href_q;
  logic [SW-1:0]       skip_q, skip_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [10:0]         cnt_q, cnt_d;
  logic                bsel_q, bsel_d;
  logic [3:0]          r_q, r_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                lerr_q, lerr_d;

  logic vs_rise, vs_fall, href_fall;
  assign vs_rise   = vsync & ~vsync_q;
  assign vs_fall   = ~vsync & vsync_q;
  assign href_fall = ~href & href_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_VS_HI;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      skip_q    <= SW'(SKIP_FRAMES);
      x_q       <= '0;
      y_q       <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      bsel_q    <= 1'b0;
      r_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync;
      href_q    <= href;
      skip_q    <= skip_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      bsel_q    <= bsel_d;
      r_q       <= r_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      lerr_q    <= lerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_VS_HI: if (vsync) state_d = ST_WAIT_VS_LO;
      ST_WAIT_VS_LO: begin
        if (vs_fall) begin
          if (!cap_en)           state_d = ST_WAIT_VS_HI;
          else if (skip_q != '0) state_d = ST_SKIP;
          else                   state_d = ST_ACTIVE;
        end
      end
      ST_SKIP:   if (vs_rise) state_d = ST_WAIT_VS_LO;
      ST_ACTIVE: if (vs_rise) state_d = ST_WAIT_VS_LO;
      default:   state_d = ST_WAIT_VS_HI;
    endcase
  end

  always_comb begin
    skip_d    = skip_q;
    x_d       = x_q;
    y_d       = y_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    bsel_d    = bsel_q;
    r_d       = r_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    lerr_d    = 1'b0;
    case (state_q)
      ST_WAIT_VS_LO: begin
        if (vs_fall) begin
          // A disabled frame start re-arms the settling skip for the next enable.
          if (!cap_en) skip_d = SW'(SKIP_FRAMES);
          x_d    = '0;
          y_d    = '0;
          row_d  = '0;
          cnt_d  = '0;
          bsel_d = 1'b0;
        end
      end
      ST_SKIP: if (vs_rise) skip_d = skip_q - SW'(1);
      ST_ACTIVE: begin
        if (href) begin
          if (!bsel_q) begin
            r_d    = d[3:0];
            bsel_d = 1'b1;
          end else begin
            bsel_d = 1'b0;
            if (x_q < X_MAX) x_d = x_q + XW'(1);
            if (cnt_q != 11'h7ff) cnt_d = cnt_q + 11'd1;
            if (x_q < X_MAX && y_q < Y_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = row_q + ADDR_W'(x_q);
              wr_data_d = {r_q, d};
            end
          end
        end
        // A pixel completing on the vsync-rise edge is still written alongside frame_done.
        if (vs_rise) begin
          done_d = (y_q != '0) || (x_q != '0) || (href && bsel_q);
          bsel_d = 1'b0;
        end else if (href_fall) begin
          bsel_d = 1'b0;
          if (x_q != '0) begin
            lerr_d = (cnt_q != 11'(H_ACTIVE));
            if (y_q < Y_MAX) begin
              y_d   = y_q + YW'(1);
              row_d = row_q + ADDR_W'(H_ACTIVE);
            end
            x_d   = '0;
            cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign line_err   = lerr_q;
endmodule
